video_timing_gen: RTL
=====================

Name: video_timing_gen

Overview:
Generates raster timing for the HDMI output path.
- Runs free on the pixel clock and produces horizontal and vertical counters.
- Produces early pixel coordinates that feed the pixel/pattern generator.
- Produces a latency-aligned `{display_enable, vsync, hsync}` bundle that feeds the `hve_sync` input of the `hdmi` block.
- Defaults give CEA 1280x720@60 at 74.25 MHz; all intervals are parameterised for other modes and for short-frame simulation.

Parameters:
- `H_ACTIVE`, 1280, active pixels per line
- `H_FP`, 110, horizontal front porch in clocks
- `H_SYNC`, 40, hsync width in clocks
- `H_BP`, 220, horizontal back porch in clocks
- `V_ACTIVE`, 720, active lines per frame
- `V_FP`, 5, vertical front porch in lines
- `V_SYNC`, 5, vsync width in lines
- `V_BP`, 20, vertical back porch in lines
- `HSYNC_POL`, 1, 1 = hsync active-high, 0 = active-low
- `VSYNC_POL`, 1, 1 = vsync active-high, 0 = active-low
- `PIXEL_LATENCY`, 2, clocks from `o_x`/`o_y` to valid RGB at the `hdmi` inputs (0..15)

Ports:
- `i_hdmi_clk`  in  1  pixel clock
- `i_reset_n`  in  1  reset; asynchronous assert, active-low
- `o_x`  out  12  horizontal counter, 0..H_TOTAL-1 (stage 0)
- `o_y`  out  12  vertical counter, 0..V_TOTAL-1 (stage 0)
- `o_active`  out  1  stage-0 active flag: `o_x < H_ACTIVE` and `o_y < V_ACTIVE`
- `o_line_start`  out  1  stage-0 pulse when `o_x == 0`
- `o_frame_start`  out  1  stage-0 pulse when `o_x == 0` and `o_y == 0`
- `o_hve_sync`  out  3  `{display_enable, vsync, hsync}`, delayed PIXEL_LATENCY clocks
- `o_frame_count`  out  16  completed-frame counter, wraps

Behaviour:
Derived totals:
- `H_TOTAL` = `H_ACTIVE + H_FP + H_SYNC + H_BP`
- `V_TOTAL` = `V_ACTIVE + V_FP + V_SYNC + V_BP`
- Elaboration error if either total exceeds 4096 or any interval is 0.

Horizontal counter:
- Increments every clock.
- At `H_TOTAL-1` it wraps to 0.

Vertical counter:
- Increments only when the horizontal counter wraps.
- At `V_TOTAL-1`, combined with a horizontal wrap, it wraps to 0.

Line layout (horizontal):
- Active region: `[0, H_ACTIVE)`
- Front porch: `[H_ACTIVE, H_ACTIVE+H_FP)`
- Hsync: `[H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)`
- Back porch: remainder of the line

Frame layout (vertical):
- Same ordering as the line layout, in lines.
- Vsync is a function of the vertical counter only, so it changes at `x == 0`.

Stage-0 flags:
- hsync is asserted when the horizontal counter is in the hsync window; vsync likewise for the vertical counter.
- Each sync is XORed with `~POL`, so the level driven is the active level when in the window.
- `display_enable` = `o_active`.
- All stage-0 outputs are registered; `o_x`/`o_y` are the counter registers themselves.

Delay line:
- The stage-0 triple passes through PIXEL_LATENCY register stages to give `o_hve_sync`.
- With PIXEL_LATENCY = 0 it is a wire from the stage-0 registers.

Frame counter:
- `o_frame_count` increments on the clock where both counters wrap together.
- Wraps 0xFFFF -> 0.

Reset (`i_reset_n` low, asynchronous):
- Counters go to 0.
- `o_frame_count` goes to 0.
- Every delay stage and `o_hve_sync` go to the inactive value `{0, ~VSYNC_POL, ~HSYNC_POL}`.
- Stage-0 flags reset to the values consistent with position (0,0): `o_active=1`, `o_line_start=1`, `o_frame_start=1`.
- The first cycle after release is therefore pixel (0,0).

Reset asserted mid-frame:
- Immediate clear as above; no partial-frame completion.
- `o_frame_count` does not increment.

Decomposition:
- Package `video_timing_pkg` holds:
  - the 720p60 constants and the 640x480@60 alternative constants;
  - localparams for `o_hve_sync` bit indices (`DE=2`, `VS=1`, `HS=0`);
  - a `hve_t` packed typedef.
- One sub-module: `sync_delay_line`, parameterised by depth and reset value. It is a generic N-stage 3-bit register pipe with async active-low reset, reused later for audio/data-island alignment.

Test Plan:
1. Small mode (`H_ACTIVE=8`, `H_FP=2`, `H_SYNC=3`, `H_BP=1`, `V_ACTIVE=4`, `V_FP=1`, `V_SYNC=2`, `V_BP=1`), latency 0, polarity 1; run 2 frames -> exactly 14 clocks per line and 8 lines per frame.
   - hsync high for x = 10..12; vsync high for y = 5..6.
   - `display_enable` high for 32 clocks per frame.
   - `o_frame_count` goes 0 -> 1 -> 2.
2. Same mode with `HSYNC_POL=0`, `VSYNC_POL=0` -> syncs low only inside their windows and high elsewhere, including during reset.
3. `PIXEL_LATENCY=3` -> `o_hve_sync` equals the stage-0 triple from exactly 3 clocks earlier on every cycle; for the first 3 cycles after reset release it holds the inactive value.
4. Assert `i_reset_n` low asynchronously at x=5, y=2 -> all outputs reach reset values before the next edge; `o_frame_count` unchanged at 0; after release `o_frame_start`=1 at (0,0).
5. Default 720p -> `H_TOTAL` = 1650, `V_TOTAL` = 750; 1,237,500 clocks between successive `o_frame_start` pulses; 921,600 DE-high cycles per frame.
6. Preload `o_frame_count` to 0xFFFF via force, complete one frame -> count reads 0x0000.

Source files
------------

// File: rtl/video_timing_gen_pkg.sv
// Shared types and mode constants for the raster timing generator.
// Other blocks on the HDMI path use the same sync bundle layout.
package video_timing_pkg;

  localparam int DE = 2;
  localparam int VS = 1;
  localparam int HS = 0;

  typedef struct packed {
    logic de;
    logic vs;
    logic hs;
  } hve_t;

  // CEA 1280x720@60, 74.25 MHz
  localparam int H_ACTIVE_720 = 1280;
  localparam int H_FP_720     = 110;
  localparam int H_SYNC_720   = 40;
  localparam int H_BP_720     = 220;
  localparam int V_ACTIVE_720 = 720;
  localparam int V_FP_720     = 5;
  localparam int V_SYNC_720   = 5;
  localparam int V_BP_720     = 20;
  localparam bit HPOL_720     = 1'b1;
  localparam bit VPOL_720     = 1'b1;

  // VGA 640x480@60, 25.175 MHz
  localparam int H_ACTIVE_480 = 640;
  localparam int H_FP_480     = 16;
  localparam int H_SYNC_480   = 96;
  localparam int H_BP_480     = 48;
  localparam int V_ACTIVE_480 = 480;
  localparam int V_FP_480     = 10;
  localparam int V_SYNC_480   = 2;
  localparam int V_BP_480     = 33;
  localparam bit HPOL_480     = 1'b0;
  localparam bit VPOL_480     = 1'b0;

  function automatic hve_t hve_idle(
    input bit vpol,
    input bit hpol
  );
    hve_t r;
    r.de = 1'b0;
    r.vs = ~vpol;
    r.hs = ~hpol;
    return r;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Stage-0 raster position and aligned sync bundle as one bundle.
// Producer drives, pattern generator / hdmi side consume.
interface video_timing_if;
  import video_timing_pkg::*;

  logic [11:0] x;
  logic [11:0] y;
  logic        active;
  logic        line_start;
  logic        frame_start;
  hve_t        hve_sync;
  logic [15:0] frame_count;

  modport master (
    output x, y, active,
    output line_start, frame_start,
    output hve_sync, frame_count
  );

  modport slave (
    input x, y, active,
    input line_start, frame_start,
    input hve_sync, frame_count
  );

endinterface

// File: rtl/video_timing_gen_sync_delay_line.sv
// Generic N-stage 3-bit register pipe with async active-low reset.
// Depth 0 degenerates to a wire.
module sync_delay_line #(
  parameter int         DEPTH   = 1,
  parameter logic [2:0] RST_VAL = 3'b000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] d,
  output logic [2:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused;
    assign unused = ^{clk, rst_n};
    assign q = d;
  end else begin : g_pipe
    logic [2:0] stage_q [DEPTH];
    logic [2:0] stage_d [DEPTH];

    always_comb begin
      stage_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RST_VAL;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Free-running raster timing: stage-0 counters/flags plus a
// latency-aligned {de, vsync, hsync} bundle for the hdmi block.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE      = H_ACTIVE_720,
  parameter int H_FP          = H_FP_720,
  parameter int H_SYNC        = H_SYNC_720,
  parameter int H_BP          = H_BP_720,
  parameter int V_ACTIVE      = V_ACTIVE_720,
  parameter int V_FP          = V_FP_720,
  parameter int V_SYNC        = V_SYNC_720,
  parameter int V_BP          = V_BP_720,
  parameter bit HSYNC_POL     = HPOL_720,
  parameter bit VSYNC_POL     = VPOL_720,
  parameter int PIXEL_LATENCY = 2
) (
  input  logic        i_hdmi_clk,
  input  logic        i_reset_n,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_active,
  output logic        o_line_start,
  output logic        o_frame_start,
  output logic [2:0]  o_hve_sync,
  output logic [15:0] o_frame_count
);

  localparam int H_TOTAL =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL =
    V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4096 || V_TOTAL > 4096 ||
      H_ACTIVE < 1 || H_FP < 1 ||
      H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 ||
      V_SYNC < 1 || V_BP < 1 ||
      PIXEL_LATENCY < 0 ||
      PIXEL_LATENCY > 15) begin : g_bad_mode
    $error("video_timing_gen: invalid mode");
  end

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END =
    12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END =
    12'(V_ACTIVE + V_FP + V_SYNC);

  localparam hve_t IDLE = hve_idle(VSYNC_POL, HSYNC_POL);
  localparam hve_t HOME = '{
    de: 1'b1, vs: ~VSYNC_POL, hs: ~HSYNC_POL
  };

  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic        active_q, active_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  hve_t        hve0_q, hve0_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        h_wrap;
  logic        v_wrap;

  // Flags are computed from the next position so they
  // line up with the counter registers they describe.
  always_comb begin
    h_wrap = (x_q == H_LAST);
    v_wrap = (y_q == V_LAST);
    x_d    = h_wrap ? 12'd0 : x_q + 12'd1;
    y_d    = y_q;
    if (h_wrap) begin
      y_d = v_wrap ? 12'd0 : y_q + 12'd1;
    end
    active_d      = (x_d < H_ACT) && (y_d < V_ACT);
    line_start_d  = (x_d == 12'd0);
    frame_start_d = (x_d == 12'd0) && (y_d == 12'd0);
    hve0_d.de = active_d;
    hve0_d.hs = ((x_d >= HS_BEG) && (x_d < HS_END))
                ^ ~HSYNC_POL;
    hve0_d.vs = ((y_d >= VS_BEG) && (y_d < VS_END))
                ^ ~VSYNC_POL;
    frame_count_d = frame_count_q;
    if (h_wrap && v_wrap) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      x_q           <= '0;
      y_q           <= '0;
      active_q      <= 1'b1;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
      hve0_q        <= HOME;
      frame_count_q <= '0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hve0_q        <= hve0_d;
      frame_count_q <= frame_count_d;
    end
  end

  sync_delay_line #(
    .DEPTH   (PIXEL_LATENCY),
    .RST_VAL (IDLE)
  ) u_dly (
    .clk   (i_hdmi_clk),
    .rst_n (i_reset_n),
    .d     (hve0_q),
    .q     (o_hve_sync)
  );

  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_active      = active_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;
  assign o_frame_count = frame_count_q;

endmodule
